// File: rtl/char_packer_pkg.sv
// Shared types for the character packer: widened characters, packet views and FSM states.
package char_packer_pkg;

    typedef logic [31:0]     character;
    typedef logic [7:0][7:0] packet_input;
    typedef logic [511:0]    packet_output;
    typedef character [15:0] packet_output_aux;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } packer_state_t;

    localparam int unsigned CHARS_PER_INPUT = 8;

    function automatic character widen_byte(input logic [7:0] b);
        return {24'h00_0000, b};
    endfunction

endpackage

// File: rtl/char_packer.sv
// Packs pairs of 8-byte input packets into one 16-character output packet.
// Optional message flush (pad + out_last) when CHAR_PACKER_FLUSH_EN is defined.
module char_packer
    import char_packer_pkg::*;
#(
    parameter character PAD_CHAR = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  packet_input  in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output packet_output out_data,
    output logic         out_valid,
    output logic         out_last,
    input  logic         out_ready
);

    packer_state_t    state_r;
    packer_state_t    base_s;
    packet_output_aux data_r;
    logic             out_valid_r;
    logic             in_fire_s;
    logic             out_fire_s;
    character [CHARS_PER_INPUT-1:0] wide_s;

    // Widen each input byte; byte i lands in half-slot i so byte 7 stays first.
    always_comb begin
        wide_s = '0;
        for (int i = 0; i < CHARS_PER_INPUT; i++) begin
            wide_s[i] = widen_byte(in_data[i]);
        end
    end

    assign in_ready   = (state_r != FULL) || out_ready;
    assign in_fire_s  = in_valid && in_ready;
    assign out_fire_s = out_valid_r && out_ready;

    // A FULL packet leaving this cycle frees the register for an incoming packet.
    always_comb begin
        if (out_fire_s) begin
            base_s = EMPTY;
        end else begin
            base_s = state_r;
        end
    end

`ifdef CHAR_PACKER_FLUSH_EN
    logic last_r;

    // Packing FSM with data and last-flag registers; flush pads the lower half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= EMPTY;
            data_r      <= '0;
            out_valid_r <= 1'b0;
            last_r      <= 1'b0;
        end else begin
            if (out_fire_s) begin
                state_r     <= EMPTY;
                out_valid_r <= 1'b0;
                last_r      <= 1'b0;
            end
            if (in_fire_s) begin
                case (base_s)
                    EMPTY: begin
                        data_r[15:8] <= wide_s;
                        if (in_last) begin
                            data_r[7:0] <= {CHARS_PER_INPUT{PAD_CHAR}};
                            state_r     <= FULL;
                            out_valid_r <= 1'b1;
                            last_r      <= 1'b1;
                        end else begin
                            state_r <= HALF;
                        end
                    end
                    HALF: begin
                        data_r[7:0] <= wide_s;
                        state_r     <= FULL;
                        out_valid_r <= 1'b1;
                        last_r      <= in_last;
                    end
                    default: state_r <= state_r;
                endcase
            end
        end
    end

    assign out_last = last_r;
`else
    logic unused_s;
    assign unused_s = in_last ^ (^PAD_CHAR);

    // Packing FSM with the data register; packets always pair strictly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= EMPTY;
            data_r      <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (out_fire_s) begin
                state_r     <= EMPTY;
                out_valid_r <= 1'b0;
            end
            if (in_fire_s) begin
                case (base_s)
                    EMPTY: begin
                        data_r[15:8] <= wide_s;
                        state_r      <= HALF;
                    end
                    HALF: begin
                        data_r[7:0] <= wide_s;
                        state_r     <= FULL;
                        out_valid_r <= 1'b1;
                    end
                    default: state_r <= state_r;
                endcase
            end
        end
    end

    assign out_last = 1'b0;
`endif

    assign out_valid = out_valid_r;
    assign out_data  = packet_output'(data_r);

endmodule

// File: tb/tb_char_packer.sv
// Self-checking bench for char_packer: vector table, corner sequences, randomized model.
module tb_char_packer;
    import char_packer_pkg::*;

    localparam character PAD = 32'h0000_002E;
    localparam logic [63:0] PA = "ABCDEFGH";
    localparam logic [63:0] PB = "IJKLMNOP";
    localparam logic [63:0] PC = "QRSTUVWX";
    localparam logic [63:0] PD = "YZ012345";
    localparam logic [63:0] PE = "abcdefgh";
    localparam logic [63:0] PF = "ijklmnop";
    localparam logic [63:0] PJ = 64'hDEAD_BEEF_0BAD_F00D;
    localparam logic [63:0] P1 = "12345678";

    logic         clk = 1'b0;
    logic         rst;
    packet_input  in_data;
    logic         in_valid, in_last, in_ready;
    packet_output out_data;
    logic         out_valid, out_last, out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    char_packer #(.PAD_CHAR(PAD)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
    );

    typedef struct {
        logic         v;
        logic [63:0]  d;
        logic         ordy;
        logic         exp_ir;
        logic         exp_ov;
        logic [511:0] exp_od;
    } vec_t;

    vec_t tbl[13];
    logic [63:0]  half_q[$];
    logic [511:0] exp_q[$];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Stream order: a's bytes MSB-first, then b's; stream position p is character 15-p.
    function automatic logic [511:0] pack_pair(input logic [63:0] a, input logic [63:0] b);
        logic [7:0]   s [16];
        logic [511:0] r;
        for (int p = 0; p < 8; p++) begin
            s[p]     = a[63-8*p -: 8];
            s[8 + p] = b[63-8*p -: 8];
        end
        r = '0;
        for (int p = 0; p < 16; p++) r[511-32*p -: 32] = {24'h0, s[p]};
        return r;
    endfunction

    function automatic logic [511:0] pack_flush(input logic [63:0] a);
        logic [511:0] r;
        r = pack_pair(a, 64'h0);
        for (int p = 8; p < 16; p++) r[511-32*p -: 32] = PAD;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [63:0] d, input logic ordy, input logic last);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        in_last   = last;
    endtask

    task automatic do_reset();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        half_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic exp_ir;
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        do_reset();

        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_last", out_last, 1'b0);
        chk("reset_out_data", out_data, 512'h0);
        chk("reset_in_ready", in_ready, 1'b1);

        tbl[0]  = '{1'b1, PA, 1'b1, 1'b1, 1'b0, 512'h0};
        tbl[1]  = '{1'b1, PB, 1'b1, 1'b1, 1'b1, pack_pair(PA, PB)};
        tbl[2]  = '{1'b0, PJ, 1'b1, 1'b1, 1'b0, 512'h0};
        tbl[3]  = '{1'b1, PC, 1'b0, 1'b1, 1'b0, 512'h0};
        tbl[4]  = '{1'b1, PD, 1'b0, 1'b1, 1'b1, pack_pair(PC, PD)};
        for (int i = 5; i <= 9; i++) tbl[i] = '{1'b1, PE, 1'b0, 1'b0, 1'b1, pack_pair(PC, PD)};
        tbl[10] = '{1'b1, PE, 1'b1, 1'b1, 1'b0, 512'h0};
        tbl[11] = '{1'b1, PF, 1'b1, 1'b1, 1'b1, pack_pair(PE, PF)};
        tbl[12] = '{1'b0, PJ, 1'b1, 1'b1, 1'b0, 512'h0};

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].ordy, 1'b0);
            #1;
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].exp_ir);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].exp_ov);
            if (tbl[i].exp_ov) chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].exp_od);
            if (i == 1) chk("abc_literal", out_data,
                512'h00000041_00000042_00000043_00000044_00000045_00000046_00000047_00000048_00000049_0000004A_0000004B_0000004C_0000004D_0000004E_0000004F_00000050);
        end

        // Eight back-to-back packets with the sink always ready.
        begin
            logic [63:0] prev;
            logic [63:0] cur;
            prev = 64'h0;
            for (int k = 0; k < 8; k++) begin
                cur = {$urandom, $urandom};
                drive(1'b1, cur, 1'b1, 1'b0);
                #1;
                chk($sformatf("b2b%0d_in_ready", k), in_ready, 1'b1);
                @(posedge clk);
                #1;
                chk($sformatf("b2b%0d_out_valid", k), out_valid, (k % 2) == 1);
                if ((k % 2) == 1) chk($sformatf("b2b%0d_out_data", k), out_data, pack_pair(prev, cur));
                prev = cur;
            end
            drive(1'b0, 64'h0, 1'b1, 1'b0);
            @(posedge clk);
            #1;
            chk("b2b_drain", out_valid, 1'b0);
        end

        // Reset while half a pair is held: the partial packet must be dropped.
        drive(1'b1, PA, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, PB, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("midrst_no_partial", out_valid, 1'b0);
        drive(1'b1, PC, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("midrst_valid", out_valid, 1'b1);
        chk("midrst_first_char", out_data[511:480], 32'h0000_0049);
        chk("midrst_data", out_data, pack_pair(PB, PC));
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;

        // Single packet flagged as end of message.
        drive(1'b1, P1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 64'h0, 1'b0, 1'b0);
`ifdef CHAR_PACKER_FLUSH_EN
        chk("flush_out_valid", out_valid, 1'b1);
        chk("flush_out_data", out_data, pack_flush(P1));
        chk("flush_out_last", out_last, 1'b1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_taken_valid", out_valid, 1'b0);
        chk("flush_taken_last", out_last, 1'b0);
`else
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("noflush_idle%0d_valid", k), out_valid, 1'b0);
            chk($sformatf("noflush_idle%0d_last", k), out_last, 1'b0);
            @(posedge clk);
            #1;
        end
        drive(1'b1, PA, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("noflush_pair_valid", out_valid, 1'b1);
        chk("noflush_pair_data", out_data, pack_pair(P1, PA));
        chk("noflush_pair_last", out_last, 1'b0);
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
`endif

        // Randomized traffic against a pairing/queue reference model.
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef CHAR_PACKER_FLUSH_EN
            in_last   = 1'b0;
`else
            in_last   = $urandom_range(0, 1) == 1;
`endif
            #1;
            exp_ir = (exp_q.size() == 0) || out_ready;
            chk("rnd_in_ready", in_ready, exp_ir);
            if (out_ready && exp_q.size() != 0) begin
                chk("rnd_out_data", out_data, exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (in_valid && exp_ir) begin
                half_q.push_back(in_data);
                if (half_q.size() == 2) begin
                    exp_q.push_back(pack_pair(half_q[0], half_q[1]));
                    half_q.delete();
                end
            end
            @(posedge clk);
            #1;
            chk("rnd_out_valid", out_valid, exp_q.size() != 0);
            chk("rnd_out_last", out_last, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/char_packer.md
# char_packer

Widening and packing stage that sits directly upstream of the consumer of `packet_output`. Accepts 8-byte `packet_input` words over a valid/ready handshake and zero-extends each byte to a 32-bit `character`. Packs two consecutive input packets into one 512-bit `packet_output` (16 characters), presented on a registered valid/ready output port. Fully pipelined: one input packet per cycle sustained when the sink is always ready.

## Interface
Parameters:
- `PAD_CHAR`, default `32'h0000_0000`: character written to unfilled slots on a flush (macro build only).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  `packet_input`  eight bytes; byte index 7 is the first character in stream order.
- `in_valid`  in  1  `in_data` holds a packet.
- `in_last`  in  1  packet ends a message (used only with the macro).
- `in_ready`  out  1  the block accepts `in_data` this cycle.
- `out_data`  out  `packet_output`  16 characters; character 15 (bits 511:480) is first in stream order.
- `out_valid`  out  1  `out_data` holds a complete packet.
- `out_last`  out  1  packet closes a message (macro build only; otherwise tied 0).
- `out_ready`  in  1  the sink takes `out_data` this cycle.

## Operation
- Transfer rules: an input transfer occurs when `in_valid && in_ready`; an output transfer occurs when `out_valid && out_ready`.
- Widening: character = `{24'h0, byte}`.
- First packet of a pair:
  - `in_data[7-i]` goes to character `15-i`, for i = 0..7.
  - Characters 15..8 fill from this packet.
- Second packet of a pair: fills characters 7..0 in the same way.
- States:
  - EMPTY: no characters held.
  - HALF: upper half loaded.
  - FULL: `out_valid=1`.
- Transitions:
  - EMPTY, input transfer → HALF.
  - HALF, input transfer → FULL.
  - FULL with output transfer and input transfer in the same cycle → HALF. The new packet loads the upper half, and the lower half is don't-care.
  - FULL with output transfer only → EMPTY.
  - FULL without output transfer → holds; `out_data` stays stable.
- `in_ready = (state != FULL) || out_ready`. This is combinational from `out_ready` only, never from `in_valid`.
- `out_valid` and `out_data` are registered and never depend combinationally on inputs.
- `in_data` sampled when `in_valid` is low is ignored.
- Reset mid-operation: any half-filled packet is discarded, and no partial packet is ever emitted.

## Timing
- Reset values: `out_valid=0`, `out_last=0`, `out_data=0`, state EMPTY, `in_ready=1`.
- Latency: `out_valid` rises the cycle after the second packet of a pair is accepted.
- Throughput: with `out_ready` held at 1, one output every 2 cycles and `in_ready` constantly 1.
- Backpressure: while FULL and `out_ready=0`, `in_ready=0`, and the upper half of the next pair is not loaded.

## Configuration
- `CHAR_PACKER_FLUSH_EN` defined (message flush enabled):
  - `in_last` accepted in EMPTY → lower characters 7..0 are set to `PAD_CHAR`, state goes to FULL, `out_last=1`.
  - `in_last` accepted in HALF → normal completion with `out_last=1`.
  - `out_last` is registered alongside `out_data` and clears on the output transfer.
- Macro undefined:
  - `in_last` is ignored and `out_last` is tied 0.
  - Packets always pair strictly.

## Structure
- Shared package:
  - `character`, `packet_input`, `packet_output`, and `packet_output_aux`.
  - A new `packer_state_t` enum {EMPTY, HALF, FULL}.
  - A new function `widen_byte(logic[7:0]) → character`.
- Internally, assemble data as `packet_output_aux` and cast it to `packet_output` at the port.
- No sub-module is needed; the 512-bit register plus the FSM form one module.

## Test plan
- Reset, then drive "ABCDEFGH" followed by "IJKLMNOP" with `out_ready=1` → one output `00000041_00000042_…_00000050`, `out_valid` high for exactly 1 cycle, 1 cycle after the second accept.
- Stream 8 back-to-back packets with `out_ready=1` → 4 outputs, `in_ready` never low, byte order preserved.
- Fill to FULL with `out_ready=0` for 5 cycles → `in_ready=0`, `out_data` stable. Raise `out_ready` with `in_valid=1` in the same cycle → output taken and new packet accepted into HALF.
- Assert `rst` in HALF after "ABCDEFGH" → `out_valid` stays 0. Then drive "IJKLMNOP","QRSTUVWX" → output begins `00000049`.
- Macro on: single packet "12345678" with `in_last=1` → output chars 15..8 = `00000031`..`00000038`, chars 7..0 = `PAD_CHAR`, `out_last=1`.
- Macro off: the same stimulus → no output until a second packet is accepted, and `out_last=0`.
